// File: rtl/image_rows2window_pkg.sv
// Shared constants and FSM encoding for the row-to-window fan-out.
package image_rows2window_pkg;

   localparam int IMAGE_WIDTH_DATA = 8;
   localparam int K_MAX            = 7;

   typedef enum logic [4:0] {
      ST_IDLE      = 5'b00001,
      ST_WAIT_ROW  = 5'b00010,
      ST_WAIT_FIFO = 5'b00100,
      ST_READ      = 5'b01000,
      ST_ROW_END   = 5'b10000
   } state_t;

endpackage

// File: rtl/image_tap_en_gen.sv
// Column-tap write-enable for tap column J: true when column col starts or lies in a
// window covered by this tap. Optional stride-2 parity term under IMAGE_STRIDE2_EN.
module image_tap_en_gen #(
   parameter int J      = 0,
   parameter int K      = 3,
   parameter int ADDR_W = 10
) (
   input  logic [ADDR_W-1:0] col,
   input  logic [ADDR_W-1:0] row_len,
`ifdef IMAGE_STRIDE2_EN
   input  logic              stride2,
`endif
   output logic              en
);

   logic [ADDR_W:0] col_x;
   logic [ADDR_W:0] hi;

   assign col_x = {1'b0, col};
   // row_len >= K whenever this is sampled, so no underflow
   assign hi    = {1'b0, row_len} - (ADDR_W+1)'(K) + (ADDR_W+1)'(J);

`ifdef IMAGE_STRIDE2_EN
   logic [ADDR_W:0] rel;
   assign rel = col_x - (ADDR_W+1)'(J);
   assign en  = (col_x >= (ADDR_W+1)'(J)) && (col_x <= hi) && (!stride2 || !rel[0]);
`else
   assign en  = (col_x >= (ADDR_W+1)'(J)) && (col_x <= hi);
`endif

endmodule

// File: rtl/image_rows2window.sv
// Row buffer to KxK window-tap FIFO fan-out. Optional stride-2 mode: IMAGE_STRIDE2_EN.
module image_rows2window
   import image_rows2window_pkg::*;
#(
   parameter int DATA_W = IMAGE_WIDTH_DATA,
   parameter int CH     = 1,
   parameter int K      = 3,
   parameter int ADDR_W = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [ADDR_W-1:0]       row_len,
   input  logic                    row_ready,
`ifdef IMAGE_STRIDE2_EN
   input  logic                    stride2,
`endif
   input  logic [K*CH*DATA_W-1:0]  s_feature,
   output logic [ADDR_W-1:0]       addr,
   output logic [K*K*CH*DATA_W-1:0] m_data,
   input  logic                    m_ready,
   output logic [K*K-1:0]          m_wr_en,
   output logic                    s_ready,
   output logic                    done
);

   localparam int PW = CH*DATA_W;

   state_t            state, nxt;
   logic [ADDR_W-1:0] col, row_cnt, step;
   logic              last_row, rd_vld;
   logic [K-1:0]      col_en;
   logic [K*K-1:0]    tap_en;

`ifdef IMAGE_STRIDE2_EN
   logic stride_q;
   always_ff @(posedge clk) begin
      if (rst)                                    stride_q <= 1'b0;
      else if (state == ST_IDLE && nxt == ST_WAIT_ROW) stride_q <= stride2;
   end
   assign step = stride_q ? ADDR_W'(2) : ADDR_W'(1);
`else
   assign step = ADDR_W'(1);
`endif

   // widened compares keep row_len == 2^ADDR_W-1 from wrapping
   assign last_row = ({1'b0, row_cnt} + {1'b0, step}) > ({1'b0, row_len} - (ADDR_W+1)'(K));
   assign rd_vld   = (state == ST_READ) && (col != row_len);
   assign addr     = rd_vld ? col : '0;

   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE:      if (start && ({1'b0, row_len} >= (ADDR_W+1)'(K))) nxt = ST_WAIT_ROW;
         ST_WAIT_ROW:  if (row_ready) nxt = ST_WAIT_FIFO;
         ST_WAIT_FIFO: if (m_ready)   nxt = ST_READ;
         ST_READ:      if (col == row_len) nxt = ST_ROW_END;
         ST_ROW_END:   nxt = last_row ? ST_IDLE : ST_WAIT_ROW;
         default:      nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         col     <= '0;
         row_cnt <= '0;
         m_wr_en <= '0;
         s_ready <= 1'b1;
         done    <= 1'b0;
      end else begin
         state   <= nxt;
         s_ready <= (nxt != ST_WAIT_ROW);
         done    <= (state == ST_ROW_END) && (nxt == ST_IDLE);
         // enables land with the read data, one cycle after addr
         m_wr_en <= rd_vld ? tap_en : '0;
         col     <= rd_vld ? col + ADDR_W'(1) : '0;
         if (state == ST_IDLE && nxt == ST_WAIT_ROW) row_cnt <= '0;
         else if (state == ST_ROW_END)               row_cnt <= row_cnt + step;
      end
   end

   genvar j, r;
   generate
      for (j = 0; j < K; j++) begin : g_col
         image_tap_en_gen #(.J(j), .K(K), .ADDR_W(ADDR_W)) u_tap (
            .col     (col),
            .row_len (row_len),
`ifdef IMAGE_STRIDE2_EN
            .stride2 (stride_q),
`endif
            .en      (col_en[j])
         );
         for (r = 0; r < K; r++) begin : g_row
            assign tap_en[r*K+j]                = col_en[j];
            assign m_data[(r*K+j)*PW +: PW]     = s_feature[r*PW +: PW];
         end
      end
   endgenerate

endmodule
